// File: rtl/seven_buffer_loader.sv
// 7x7 pixel window loader: full 49-pixel loads or single line/column shifts
// (right, left, down) staged then committed in one edge for the gradient stage.
module seven_buffer_loader #(
   parameter int PIX_W = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd_valid,
   input  logic [1:0]                    cmd,
   output logic                          cmd_ready,
   input  logic                          pix_valid,
   input  logic [PIX_W-1:0]              pix_data,
   output logic                          pix_ready,
   output logic [0:6][0:6][PIX_W-1:0]    seven_buffer_out,
   output logic [1:0]                    grad_shift,
   output logic                          win_valid
);

   typedef enum logic [1:0] {IDLE, FULL_LOAD, LINE_LOAD, COMMIT} state_t;

   state_t                    r_state, w_state_next;
   logic [1:0]                r_cmd;
   logic [5:0]                r_pix_cnt;
   logic                      r_loaded, w_loaded_next;
   logic [1:0]                r_grad_shift;
   logic                      r_win_valid;
   logic [0:48][PIX_W-1:0]    r_win, w_win_next;
   logic [0:6][PIX_W-1:0]     r_stage;
   logic                      w_cmd_acc, w_pix_acc, w_last_pix, w_commit;

   always_comb begin
      w_state_next = r_state;
      cmd_ready    = 1'b0;
      pix_ready    = 1'b0;
      w_cmd_acc    = 1'b0;
      w_pix_acc    = 1'b0;
      w_last_pix   = 1'b0;
      case (r_state)
         IDLE: begin
            cmd_ready = 1'b1;
            w_cmd_acc = cmd_valid;
            if (cmd_valid)
               w_state_next = (cmd == 2'b00) ? FULL_LOAD : LINE_LOAD;
         end
         FULL_LOAD: begin
            pix_ready  = 1'b1;
            w_pix_acc  = pix_valid;
            w_last_pix = (r_pix_cnt == 6'd48);
            if (pix_valid && w_last_pix)
               w_state_next = COMMIT;
         end
         LINE_LOAD: begin
            pix_ready  = 1'b1;
            w_pix_acc  = pix_valid;
            w_last_pix = (r_pix_cnt == 6'd6);
            if (pix_valid && w_last_pix)
               w_state_next = COMMIT;
         end
         COMMIT:  w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   assign w_commit      = (r_state == COMMIT);
   assign w_loaded_next = (w_commit && r_cmd == 2'b00) ? 1'b1 : r_loaded;

   // Each cell picks its neighbour (or staged edge pixel) for the committed shift.
   genvar gi;
   generate
      for (gi = 0; gi < 49; gi++) begin : g_cell
         localparam int ROW = gi / 7;
         localparam int COL = gi % 7;
         logic [PIX_W-1:0] w_right, w_left, w_down;
         logic             w_wr;

         if (COL == 6) begin : g_right_edge
            assign w_right = r_stage[ROW];
         end else begin : g_right_in
            assign w_right = r_win[gi+1];
         end
         if (COL == 0) begin : g_left_edge
            assign w_left = r_stage[ROW];
         end else begin : g_left_in
            assign w_left = r_win[gi-1];
         end
         if (ROW == 6) begin : g_down_edge
            assign w_down = r_stage[COL];
         end else begin : g_down_in
            assign w_down = r_win[gi+7];
         end

         assign w_wr = w_pix_acc && (r_state == FULL_LOAD) && (r_pix_cnt == 6'(gi));
         assign w_win_next[gi] = w_wr                  ? pix_data :
                                 !w_commit             ? r_win[gi] :
                                 (r_cmd == 2'b01)      ? w_right :
                                 (r_cmd == 2'b10)      ? w_left :
                                 (r_cmd == 2'b11)      ? w_down : r_win[gi];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_cmd        <= 2'b00;
         r_pix_cnt    <= '0;
         r_loaded     <= 1'b0;
         r_stage      <= '0;
         r_win        <= '0;
         r_grad_shift <= 2'b00;
         r_win_valid  <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_win       <= w_win_next;
         r_win_valid <= 1'b0;
         if (w_cmd_acc) begin
            r_cmd     <= cmd;
            r_pix_cnt <= '0;
            if (cmd == 2'b00)
               r_loaded <= 1'b0;
         end
         if (w_pix_acc) begin
            // Hold at the final index so the count never passes 48.
            if (!w_last_pix)
               r_pix_cnt <= r_pix_cnt + 6'd1;
            if (r_state == LINE_LOAD)
               r_stage[r_pix_cnt[2:0]] <= pix_data;
         end
         if (w_commit) begin
            r_loaded     <= w_loaded_next;
            r_grad_shift <= r_cmd;
            r_win_valid  <= w_loaded_next;
         end
      end
   end

   assign seven_buffer_out = r_win;
   assign grad_shift       = r_grad_shift;
   assign win_valid        = r_win_valid;

endmodule

// File: tb/tb_seven_buffer_loader.sv
// Directed bench for seven_buffer_loader: table of commands checked against a
// small window model, plus hand sequences for reset behaviour.
module tb_seven_buffer_loader;

   logic                    clk;
   logic                    rst;
   logic                    cmd_valid;
   logic [1:0]              cmd;
   logic                    cmd_ready;
   logic                    pix_valid;
   logic [7:0]              pix_data;
   logic                    pix_ready;
   logic [0:6][0:6][7:0]    win_out;
   logic [1:0]              grad_shift;
   logic                    win_valid;

   seven_buffer_loader #(.PIX_W(8)) dut (
      .clk              (clk),
      .rst              (rst),
      .cmd_valid        (cmd_valid),
      .cmd              (cmd),
      .cmd_ready        (cmd_ready),
      .pix_valid        (pix_valid),
      .pix_data         (pix_data),
      .pix_ready        (pix_ready),
      .seven_buffer_out (win_out),
      .grad_shift       (grad_shift),
      .win_valid        (win_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] cmd;
      int         base;
      bit         stall;
      logic [1:0] exp_grad;
      bit         exp_wv;
      int         chk_r;
      int         chk_c;
      int         chk_v;
   } vec_t;

   vec_t vecs [0:5];
   int   n_checks = 0;
   int   n_errors = 0;
   int   m [0:6][0:6];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic window_cmp(input string name);
      int bad = 0;
      int br = 0, bc = 0;
      for (int r = 0; r < 7; r++)
         for (int c = 0; c < 7; c++)
            if (int'(win_out[r][c]) != m[r][c]) begin
               if (bad == 0) begin br = r; bc = c; end
               bad++;
            end
      n_checks++;
      if (bad != 0) begin
         n_errors++;
         $display("FAIL %s cell[%0d][%0d] actual=%0d expected=%0d (%0d bad cells)",
                  name, br, bc, win_out[br][bc], m[br][bc], bad);
      end
   endtask

   task automatic model_update(input logic [1:0] cc, input int base);
      case (cc)
         2'b00: for (int r = 0; r < 7; r++)
                   for (int c = 0; c < 7; c++) m[r][c] = base + 7*r + c;
         2'b01: for (int r = 0; r < 7; r++) begin
                   for (int c = 0; c < 6; c++) m[r][c] = m[r][c+1];
                   m[r][6] = base + r;
                end
         2'b10: for (int r = 0; r < 7; r++) begin
                   for (int c = 6; c > 0; c--) m[r][c] = m[r][c-1];
                   m[r][0] = base + r;
                end
         default: for (int c = 0; c < 7; c++) begin
                   for (int r = 0; r < 6; r++) m[r][c] = m[r+1][c];
                   m[6][c] = base + c;
                end
      endcase
   endtask

   task automatic model_clear();
      for (int r = 0; r < 7; r++)
         for (int c = 0; c < 7; c++) m[r][c] = 0;
   endtask

   task automatic run_cmd(input logic [1:0] cc, input int base, input bit stall,
                          input logic [1:0] eg, input bit ewv);
      int  n, acc, cyc;
      bit  taken;
      n   = (cc == 2'b00) ? 49 : 7;
      cmd = cc;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("pix_ready_after_cmd", pix_ready, 1);
      chk("cmd_ready_in_load", cmd_ready, 0);
      acc = 0;
      cyc = 0;
      while (acc < n && cyc < 1000) begin
         pix_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         pix_data  = pix_valid ? 8'(base + acc) : 8'hEE;
         cmd_valid = stall;
         cmd       = 2'b00;
         taken     = pix_valid && pix_ready;
         @(posedge clk); #1;
         if (taken) acc++;
         cyc++;
      end
      pix_valid = 1'b0;
      cmd_valid = 1'b0;
      chk("pixels_consumed", acc, n);
      chk("win_valid_before_commit", win_valid, 0);
      chk("pix_ready_in_commit", pix_ready, 0);
      if (cc == 2'b00) model_update(cc, base);
      window_cmp("window_before_commit");
      if (cc != 2'b00) model_update(cc, base);
      @(posedge clk); #1;
      chk("win_valid_after_commit", win_valid, ewv);
      chk("grad_shift", grad_shift, eg);
      chk("cmd_ready_idle", cmd_ready, 1);
      window_cmp("window_after_commit");
      @(posedge clk); #1;
      chk("win_valid_one_cycle", win_valid, 0);
      $display("cmd=%0d base=%0d stall=%0d grad=%0d win_valid_exp=%0d", cc, base, stall, eg, ewv);
   endtask

   initial begin
      vecs[0] = '{cmd: 2'b11, base: 10,  stall: 1'b0, exp_grad: 2'b11, exp_wv: 1'b0, chk_r: 6, chk_c: 3, chk_v: 13};
      vecs[1] = '{cmd: 2'b00, base: 0,   stall: 1'b0, exp_grad: 2'b00, exp_wv: 1'b1, chk_r: 3, chk_c: 4, chk_v: 25};
      vecs[2] = '{cmd: 2'b11, base: 200, stall: 1'b1, exp_grad: 2'b11, exp_wv: 1'b1, chk_r: 5, chk_c: 2, chk_v: 44};
      vecs[3] = '{cmd: 2'b10, base: 50,  stall: 1'b1, exp_grad: 2'b10, exp_wv: 1'b1, chk_r: 4, chk_c: 0, chk_v: 54};
      vecs[4] = '{cmd: 2'b00, base: 0,   stall: 1'b0, exp_grad: 2'b00, exp_wv: 1'b1, chk_r: 6, chk_c: 6, chk_v: 48};
      vecs[5] = '{cmd: 2'b01, base: 100, stall: 1'b1, exp_grad: 2'b01, exp_wv: 1'b1, chk_r: 2, chk_c: 5, chk_v: 20};

      rst = 1'b1; cmd_valid = 1'b0; cmd = 2'b00; pix_valid = 1'b0; pix_data = 8'h00;
      model_clear();
      #2;
      chk("reset_cmd_ready", cmd_ready, 1);
      chk("reset_pix_ready", pix_ready, 0);
      chk("reset_win_valid", win_valid, 0);
      chk("reset_grad_shift", grad_shift, 0);
      window_cmp("reset_window");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) begin
         run_cmd(vecs[i].cmd, vecs[i].base, vecs[i].stall, vecs[i].exp_grad, vecs[i].exp_wv);
         chk($sformatf("spot_vec%0d", i), win_out[vecs[i].chk_r][vecs[i].chk_c], vecs[i].chk_v);
      end
      chk("spot_col6_after_shift_right", win_out[2][6], 102);

      // Reset in the middle of a full load.
      cmd = 2'b00; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         pix_valid = 1'b1;
         pix_data  = 8'(i);
         @(posedge clk); #1;
      end
      pix_valid = 1'b0;
      chk("partial_load_cell19", win_out[2][5], 19);
      #2 rst = 1'b1;
      #1;
      model_clear();
      chk("midrst_cmd_ready", cmd_ready, 1);
      chk("midrst_pix_ready", pix_ready, 0);
      chk("midrst_win_valid", win_valid, 0);
      chk("midrst_grad_shift", grad_shift, 0);
      window_cmp("midrst_window");
      @(posedge clk); #1;
      rst = 1'b0;
      pix_valid = 1'b1;
      pix_data  = 8'h77;
      @(posedge clk); #1;
      pix_valid = 1'b0;
      chk("post_rst_pix_ready", pix_ready, 0);
      window_cmp("post_rst_pixel_ignored");
      $display("mid-load reset sequence done");

      run_cmd(2'b00, 0, 1'b0, 2'b00, 1'b1);
      chk("reload_spot", win_out[4][1], 29);
      run_cmd(2'b01, 100, 1'b0, 2'b01, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/seven_buffer_loader.md
SEVEN_BUFFER_LOADER -- requirements
Module: seven_buffer_loader

Interface
REQ-001 Parameter: PIX_W, default 8, pixel width in bits.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: cmd_valid  input  1  command offered.
REQ-006 Port: cmd  input  2  command code: 00 full load, 01 shift right, 10 shift left, 11 shift down.
REQ-007 Port: cmd_ready  output  1  command can be accepted.
REQ-008 Port: pix_valid  input  1  pixel offered.
REQ-009 Port: pix_data  input  PIX_W  pixel value.
REQ-010 Port: pix_ready  output  1  pixel can be accepted.
REQ-011 Port: seven_buffer_out  output  PIX_W x [0:6][0:6]  window, indexed [row][col].
REQ-012 Port: grad_shift  output  2  code of the last committed command, used by the gradient stage.
REQ-013 Port: win_valid  output  1  one-cycle strobe when a committed window is ready.

Function
REQ-014 The FSM SHALL have four states: IDLE, FULL_LOAD, LINE_LOAD and COMMIT.
REQ-015 cmd_ready SHALL be 1 only in IDLE; pix_ready SHALL be 1 only in FULL_LOAD and LINE_LOAD.
REQ-016 In IDLE, cmd_valid&cmd_ready SHALL latch cmd, clear pix_cnt, and go to FULL_LOAD if cmd==00, otherwise to LINE_LOAD.
REQ-017 A pixel SHALL be accepted only on a cycle with pix_valid&pix_ready; pix_cnt SHALL increment per accepted pixel.
REQ-018 FULL_LOAD SHALL write each accepted pixel directly into the window in row-major order ([0][0] first, [6][6] last); it SHALL go to COMMIT on the 49th accepted pixel.
REQ-019 LINE_LOAD SHALL write accepted pixels into a 7-entry staging register, leaving the window unchanged.
REQ-020 LINE_LOAD pixel order: cmd 01/10 SHALL use rows 0..6 top to bottom; cmd 11 SHALL use cols 0..6 left to right.
REQ-021 LINE_LOAD SHALL go to COMMIT on the 7th accepted pixel.
REQ-022 COMMIT, cmd 01: for every row r and c=0..5, window[r][c] <= window[r][c+1]; window[r][6] <= stage[r].
REQ-023 COMMIT, cmd 10: for every row r and c=1..6, window[r][c] <= window[r][c-1]; window[r][0] <= stage[r].
REQ-024 COMMIT, cmd 11: for every column c and r=0..5, window[r][c] <= window[r+1][c]; window[6][c] <= stage[c].
REQ-025 COMMIT, cmd 00: the window SHALL be unchanged (already written) and the loaded flag SHALL be set to 1.
REQ-026 Window update timing: LINE_LOAD commands update the window on the COMMIT edge; FULL_LOAD updates the window per pixel.
REQ-027 The COMMIT edge SHALL register grad_shift <= latched cmd; grad_shift SHALL hold until the next COMMIT.
REQ-028 The COMMIT edge SHALL register win_valid <= loaded_next; win_valid SHALL be 1 for exactly the one cycle after COMMIT (while in IDLE) and 0 otherwise.
REQ-029 COMMIT SHALL last one cycle and go to IDLE.
REQ-030 Latency from the last accepted pixel to win_valid SHALL be 2 edges.
REQ-031 A shift command before any full load SHALL be executed (window shifts) with win_valid kept 0.
REQ-032 A full load SHALL clear the loaded flag at acceptance and set it at COMMIT.
REQ-033 pix_valid while pix_ready=0 SHALL be ignored with no data loss requirement; cmd_valid outside IDLE SHALL be ignored.
REQ-034 pix_cnt SHALL be 6 bits, counting 0..48, and SHALL never wrap within a command.

Reset
REQ-035 While rst=1 the block SHALL be asynchronously forced to state IDLE with pix_cnt=0, loaded=0, staging=0, all window entries=0, grad_shift=00 and win_valid=0.
REQ-036 Resulting output values in reset: cmd_ready=1 and pix_ready=0.
REQ-037 Reset asserted mid-load SHALL discard the partial command; after deassert, a fresh cmd SHALL be required.

Verification
REQ-038 Full load, pixels 0..48 with no stalls -> window[r][c]=7r+c, win_valid=1 exactly one cycle (2 edges after the 49th pixel), grad_shift=00.
REQ-039 After full load, cmd 01 with pixels 100..106 -> window[r][5]=7r+6, window[r][6]=100+r, grad_shift=01, win_valid pulse.
REQ-040 After full load, cmd 11 with pixels 200..206 -> window[5][c]=42+c, window[6][c]=200+c, grad_shift=11; a following cmd 10 with 50..56 -> window[r][0]=50+r.
REQ-041 pix_valid toggled randomly during LINE_LOAD -> window unchanged until COMMIT; exactly 7 pixels consumed; cmd_valid during load ignored.
REQ-042 Shift command issued directly after reset -> window shifts, win_valid stays 0, grad_shift updates.
REQ-043 rst pulsed after the 20th pixel of a full load -> all outputs at reset values; a new full load completes correctly.
